simt_stack: RTL and testbench

Multi-warp SIMT reconvergence stack that replaces the single-warp, fixed-depth per-warp stack. One instance serves `NUM_WARPS` warps, each with an independent stack of `STACK_DEPTH` entries. Each entry holds a type, a PC and a thread mask. The block sits beside the warp scheduler. The pipeline issues one push, pop or flush per cycle, and the scheduler reads the top of any warp's stack with one-cycle latency. Compared with the previous block it adds:

- explicit full and empty flags per warp;
- rejection of overflow and underflow, with a sticky error flag;
- a per-warp flush;
- a read bypass, so the top read back always reflects the last accepted operation.

---
 rtl/simt_stack_pkg.sv | 36 +++
 rtl/simt_stack_ram.sv | 29 ++
 rtl/simt_stack.sv | 138 +++++++++++++
 tb/tb_simt_stack.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simt_stack_pkg.sv
// rtl/simt_stack_pkg.sv - shared op codes, entry types and entry layout for the SIMT stack
package simt_stack_pkg;

  // Pipeline operation codes
  localparam logic [1:0] OP_PUSH_SYNC   = 2'b00;
  localparam logic [1:0] OP_PUSH_DIV    = 2'b01;
  localparam logic [1:0] OP_PUSH_REPLAY = 2'b10;
  localparam logic [1:0] OP_POP         = 2'b11;

  // Entry types as stored and reported on the read port; 00 never appears on a valid entry
  localparam logic [1:0] TYPE_NONE   = 2'b00;
  localparam logic [1:0] TYPE_SYNC   = 2'b01;
  localparam logic [1:0] TYPE_DIV    = 2'b10;
  localparam logic [1:0] TYPE_REPLAY = 2'b11;

  // Default entry field widths
  localparam int PC_W   = 10;
  localparam int MASK_W = 32;

  typedef struct packed {
    logic [1:0]        typ;
    logic [PC_W-1:0]   pc;
    logic [MASK_W-1:0] mask;
  } stack_entry_t;

  // Map a push op code onto the entry type it records
  function automatic logic [1:0] entry_type(input logic [1:0] code);
    case (code)
      OP_PUSH_SYNC:   entry_type = TYPE_SYNC;
      OP_PUSH_DIV:    entry_type = TYPE_DIV;
      OP_PUSH_REPLAY: entry_type = TYPE_REPLAY;
      default:        entry_type = TYPE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/simt_stack_ram.sv
// rtl/simt_stack_ram.sv - entry storage for all warps, one write port and one registered read port
module simt_stack_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 44
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write port; contents are never reset, counts decide what is live
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Synchronous read; a same-address write returns old data and is covered by the caller's bypass
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/simt_stack.sv
// rtl/simt_stack.sv - multi-warp SIMT reconvergence stack with flags, error capture and read bypass
module simt_stack
  import simt_stack_pkg::*;
#(
  parameter int NUM_WARPS    = 8,
  parameter int STACK_DEPTH  = 16,
  parameter int WARP_WIDTH   = 32,
  parameter int I_ADDR_WIDTH = 10,
  parameter int WID_W        = $clog2(NUM_WARPS),
  parameter int PTR_W        = $clog2(STACK_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid,
  input  logic [1:0]              op_code,
  input  logic                    op_flush,
  input  logic [WID_W-1:0]        op_warp,
  input  logic [I_ADDR_WIDTH-1:0] op_pc,
  input  logic [WARP_WIDTH-1:0]   op_mask,
  output logic                    op_ok,
  input  logic [WID_W-1:0]        rd_warp,
  output logic                    rd_valid,
  output logic [1:0]              rd_type,
  output logic [I_ADDR_WIDTH-1:0] rd_pc,
  output logic [WARP_WIDTH-1:0]   rd_mask,
  output logic [PTR_W:0]          rd_count,
  output logic [NUM_WARPS-1:0]    full,
  output logic [NUM_WARPS-1:0]    empty,
  output logic                    err,
  output logic [WID_W-1:0]        err_warp
);

  localparam int ENTRY_W = 2 + I_ADDR_WIDTH + WARP_WIDTH;
  localparam int ADDR_W  = WID_W + PTR_W;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(STACK_DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

  logic [PTR_W:0]       cnt_q [NUM_WARPS];
  logic [PTR_W:0]       cnt_d [NUM_WARPS];
  logic [PTR_W:0]       cur_cnt;
  logic                 is_push;
  logic                 accept;
  logic                 wr_en;
  logic [ENTRY_W-1:0]   wr_entry;
  logic [PTR_W:0]       rd_post_cnt;
  logic [PTR_W-1:0]     rd_ptr;
  logic [ENTRY_W-1:0]   ram_rdata;
  logic [ENTRY_W-1:0]   rd_entry;
  logic                 op_ok_q;
  logic                 err_q;
  logic [WID_W-1:0]     err_warp_q;
  logic [PTR_W:0]       rd_count_q;
  logic                 bypass_q;
  logic [ENTRY_W-1:0]   byp_entry_q;

  // Accept/reject decision for the presented operation and the entry a push would store
  always_comb begin
    cur_cnt  = cnt_q[op_warp];
    is_push  = (op_code != OP_POP);
    accept   = 1'b1;
    if (!op_flush) begin
      if (is_push) accept = (cur_cnt != DEPTH_C);
      else         accept = (cur_cnt != '0);
    end
    // A push under reset must not disturb memory either
    wr_en    = rst && op_valid && !op_flush && is_push && accept;
    wr_entry = {entry_type(op_code), op_pc, op_mask};
  end

  // Post-operation counts; only the target warp can move
  always_comb begin
    cnt_d = cnt_q;
    if (op_valid && accept) begin
      if (op_flush)     cnt_d[op_warp] = '0;
      else if (is_push) cnt_d[op_warp] = cur_cnt + ONE_C;
      else              cnt_d[op_warp] = cur_cnt - ONE_C;
    end
  end

  // Read address uses the post-operation count so a pop exposes the entry beneath it
  always_comb begin
    rd_post_cnt = cnt_d[rd_warp];
    rd_ptr      = rd_post_cnt[PTR_W-1:0] - PTR_W'(1);
  end

  // State registers: counts, handshake, sticky error and read-side pipeline
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int w = 0; w < NUM_WARPS; w++) cnt_q[w] <= '0;
      op_ok_q     <= 1'b0;
      err_q       <= 1'b0;
      err_warp_q  <= '0;
      rd_count_q  <= '0;
      bypass_q    <= 1'b0;
      byp_entry_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      op_ok_q     <= op_valid && accept;
      if (op_valid && !accept) begin
        err_q <= 1'b1;
        if (!err_q) err_warp_q <= op_warp;
      end
      rd_count_q  <= rd_post_cnt;
      bypass_q    <= wr_en && (op_warp == rd_warp);
      byp_entry_q <= wr_entry;
    end
  end

  simt_stack_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (ENTRY_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i ({op_warp, cur_cnt[PTR_W-1:0]}),
    .wdata_i (wr_entry),
    .raddr_i ({rd_warp, rd_ptr}),
    .rdata_o (ram_rdata)
  );

  // Top-of-stack view: freshly pushed entry wins over the RAM, and empty stacks read as zero
  always_comb begin
    rd_entry = bypass_q ? byp_entry_q : ram_rdata;
    rd_valid = (rd_count_q != '0);
    {rd_type, rd_pc, rd_mask} = rd_valid ? rd_entry : '0;
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_flags
    assign full[w]  = (cnt_q[w] == DEPTH_C);
    assign empty[w] = (cnt_q[w] == '0);
  end

  assign op_ok    = op_ok_q;
  assign rd_count = rd_count_q;
  assign err      = err_q;
  assign err_warp = err_warp_q;

endmodule

// File: tb/tb_simt_stack.sv
// tb/tb_simt_stack.sv - scoreboard bench for simt_stack
module tb_simt_stack;

  localparam int NW  = 8;
  localparam int SD  = 16;
  localparam int WW  = 32;
  localparam int IW  = 10;
  localparam int WID = 3;
  localparam int PW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_valid = 1'b0;
  logic [1:0]    op_code = 2'b00;
  logic          op_flush = 1'b0;
  logic [WID-1:0] op_warp = '0;
  logic [IW-1:0] op_pc = '0;
  logic [WW-1:0] op_mask = '0;
  logic          op_ok;
  logic [WID-1:0] rd_warp = '0;
  logic          rd_valid;
  logic [1:0]    rd_type;
  logic [IW-1:0] rd_pc;
  logic [WW-1:0] rd_mask;
  logic [PW:0]   rd_count;
  logic [NW-1:0] full;
  logic [NW-1:0] empty;
  logic          err;
  logic [WID-1:0] err_warp;

  always #5 clk = ~clk;

  simt_stack #(
    .NUM_WARPS(NW), .STACK_DEPTH(SD), .WARP_WIDTH(WW), .I_ADDR_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_flush(op_flush),
    .op_warp(op_warp), .op_pc(op_pc), .op_mask(op_mask), .op_ok(op_ok),
    .rd_warp(rd_warp), .rd_valid(rd_valid), .rd_type(rd_type), .rd_pc(rd_pc),
    .rd_mask(rd_mask), .rd_count(rd_count), .full(full), .empty(empty),
    .err(err), .err_warp(err_warp)
  );

  typedef struct packed {
    logic           ok;
    logic           valid;
    logic [1:0]     typ;
    logic [IW-1:0]  pc;
    logic [WW-1:0]  mask;
    logic [PW:0]    count;
    logic [NW-1:0]  full;
    logic [NW-1:0]  empty;
    logic           err;
    logic [WID-1:0] ew;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  int             m_cnt  [NW];
  logic [1:0]     m_typ  [NW][SD];
  logic [IW-1:0]  m_pc   [NW][SD];
  logic [WW-1:0]  m_mask [NW][SD];
  logic           m_err = 1'b0;
  logic [WID-1:0] m_ew = '0;

  // Drive one cycle of stimulus at the falling edge and queue what the outputs must show after the next rising edge
  task automatic step(input logic r, input logic v, input logic fl, input logic [1:0] code,
                      input int w, input logic [IW-1:0] pc, input logic [WW-1:0] mask, input int rw);
    exp_t e;
    bit acc;
    @(negedge clk);
    rst = r; op_valid = v; op_flush = fl; op_code = code; op_warp = WID'(w);
    op_pc = pc; op_mask = mask; rd_warp = WID'(rw);
    e = '0;
    if (!r) begin
      for (int i = 0; i < NW; i++) m_cnt[i] = 0;
      m_err = 1'b0;
      m_ew = '0;
    end else begin
      acc = 1'b1;
      if (v) begin
        if (fl) m_cnt[w] = 0;
        else if (code == 2'b11) begin
          if (m_cnt[w] == 0) acc = 1'b0; else m_cnt[w] = m_cnt[w] - 1;
        end else if (m_cnt[w] == SD) acc = 1'b0;
        else begin
          m_typ[w][m_cnt[w]]  = code + 2'd1;
          m_pc[w][m_cnt[w]]   = pc;
          m_mask[w][m_cnt[w]] = mask;
          m_cnt[w] = m_cnt[w] + 1;
        end
        if (!acc) begin
          if (!m_err) m_ew = WID'(w);
          m_err = 1'b1;
        end
      end
      e.ok = v && acc;
      if (m_cnt[rw] > 0) begin
        e.valid = 1'b1;
        e.typ   = m_typ[rw][m_cnt[rw]-1];
        e.pc    = m_pc[rw][m_cnt[rw]-1];
        e.mask  = m_mask[rw][m_cnt[rw]-1];
      end
      e.count = (PW+1)'(m_cnt[rw]);
    end
    for (int i = 0; i < NW; i++) begin
      e.full[i]  = (m_cnt[i] == SD);
      e.empty[i] = (m_cnt[i] == 0);
    end
    e.err = m_err;
    e.ew  = m_ew;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: compare each queued expectation shortly after the edge that produced it
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (op_ok !== e.ok) begin
        failures++;
        $display("FAIL sb_op_ok got=%b exp=%b t=%0t", op_ok, e.ok, $time);
      end
      checks++;
      if ({rd_valid, rd_type, rd_pc, rd_mask, rd_count} !== {e.valid, e.typ, e.pc, e.mask, e.count}) begin
        failures++;
        $display("FAIL sb_rd got v=%b t=%b pc=%h m=%h c=%0d exp v=%b t=%b pc=%h m=%h c=%0d t=%0t",
                 rd_valid, rd_type, rd_pc, rd_mask, rd_count, e.valid, e.typ, e.pc, e.mask, e.count, $time);
      end
      checks++;
      if ({full, empty, err, err_warp} !== {e.full, e.empty, e.err, e.ew}) begin
        failures++;
        $display("FAIL sb_flags got full=%b empty=%b err=%b ew=%0d exp full=%b empty=%b err=%b ew=%0d t=%0t",
                 full, empty, err, err_warp, e.full, e.empty, e.err, e.ew, $time);
      end
    end
  end

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 2'b00, 0, '0, '0, 0);
    step(1'b1, 1'b0, 1'b0, 2'b00, 0, '0, '0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++;
    if (empty !== 8'hFF || full !== 8'h00 || err !== 1'b0 || rd_count !== 5'd0) begin
      failures++;
      $display("FAIL reset_flags got empty=%b full=%b err=%b cnt=%0d exp empty=11111111 full=0 err=0 cnt=0",
               empty, full, err, rd_count);
    end
  endtask

  task automatic test_push_read();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 2'b00, 3, 10'h040, 32'hFFFF_FFFF, 3);
    settle();
    checks++;
    if (rd_valid !== 1'b1 || rd_type !== 2'b01 || rd_pc !== 10'h040 || rd_count !== 5'd1 || empty[3] !== 1'b0 || op_ok !== 1'b1) begin
      failures++;
      $display("FAIL push_read got v=%b t=%b pc=%h c=%0d e3=%b ok=%b exp v=1 t=01 pc=040 c=1 e3=0 ok=1",
               rd_valid, rd_type, rd_pc, rd_count, empty[3], op_ok);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < SD; i++) step(1'b1, 1'b1, 1'b0, 2'(i % 3), 0, IW'(i + 16), WW'(i * 7 + 1), 0);
    step(1'b1, 1'b1, 1'b0, 2'b00, 0, 10'h3FF, 32'h1, 0);
    settle();
    checks++;
    if (full[0] !== 1'b1 || op_ok !== 1'b0 || err !== 1'b1 || err_warp !== 3'd0 || rd_count !== 5'd16) begin
      failures++;
      $display("FAIL overflow got full0=%b ok=%b err=%b ew=%0d c=%0d exp full0=1 ok=0 err=1 ew=0 c=16",
               full[0], op_ok, err, err_warp, rd_count);
    end
    for (int i = 0; i < SD; i++) step(1'b1, 1'b1, 1'b0, 2'b11, 0, '0, '0, 0);
  endtask

  task automatic test_bypass();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 2'b01, 5, 10'h011, 32'h0000_00FF, 5);
    step(1'b1, 1'b1, 1'b0, 2'b10, 5, 10'h012, 32'h0000_000F, 5);
    step(1'b1, 1'b1, 1'b0, 2'b00, 2, 10'h222, 32'hAAAA_5555, 5);
    step(1'b1, 1'b1, 1'b0, 2'b11, 5, '0, '0, 5);
    settle();
    checks++;
    if (rd_type !== 2'b10 || rd_pc !== 10'h011 || rd_mask !== 32'h0000_00FF || rd_count !== 5'd1) begin
      failures++;
      $display("FAIL bypass_pop got t=%b pc=%h m=%h c=%0d exp t=10 pc=011 m=000000ff c=1", rd_type, rd_pc, rd_mask, rd_count);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 2'b11, 2, '0, '0, 2);
    settle();
    checks++;
    if (op_ok !== 1'b0 || err !== 1'b1 || err_warp !== 3'd2 || rd_valid !== 1'b0 || rd_pc !== 10'h0) begin
      failures++;
      $display("FAIL underflow got ok=%b err=%b ew=%0d v=%b pc=%h exp ok=0 err=1 ew=2 v=0 pc=0", op_ok, err, err_warp, rd_valid, rd_pc);
    end
    step(1'b1, 1'b1, 1'b0, 2'b11, 4, '0, '0, 4);
    settle();
    checks++;
    if (err_warp !== 3'd2) begin
      failures++;
      $display("FAIL err_warp_sticky got=%0d exp=2", err_warp);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 2'(i), 1, IW'(10'h100 + i), WW'(32'h10 << i), 6);
      step(1'b1, 1'b1, 1'b0, 2'(i), 6, IW'(10'h200 + i), WW'(32'h100 << i), 1);
    end
    step(1'b1, 1'b1, 1'b1, 2'b00, 1, '0, '0, 6);
    settle();
    checks++;
    if (empty[1] !== 1'b1 || rd_count !== 5'd3 || rd_pc !== 10'h202) begin
      failures++;
      $display("FAIL flush got e1=%b c=%0d pc=%h exp e1=1 c=3 pc=202", empty[1], rd_count, rd_pc);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 2'b11, 6, '0, '0, 6);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1, 10'h0AB, 32'hC, 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 2'b00, 7, 10'h077, 32'h7, 7);
    step(1'b1, 1'b1, 1'b0, 2'b11, 3, '0, '0, 7);
    step(1'b0, 1'b1, 1'b0, 2'b01, 7, 10'h078, 32'h8, 7);
    settle();
    checks++;
    if (empty !== 8'hFF || full !== 8'h00 || err !== 1'b0 || err_warp !== 3'd0 || op_ok !== 1'b0 || rd_valid !== 1'b0 || rd_count !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid got empty=%b full=%b err=%b ew=%0d ok=%b v=%b c=%0d exp all reset values",
               empty, full, err, err_warp, op_ok, rd_valid, rd_count);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int rw;
    int sel;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      w   = $urandom_range(NW - 1);
      rw  = ($urandom_range(1) == 1) ? w : $urandom_range(NW - 1);
      sel = $urandom_range(31);
      if (sel == 0)       step(1'b1, 1'b1, 1'b1, 2'(sel), w, '0, '0, rw);
      else if (sel < 4)   step(1'b1, 1'b0, 1'b0, 2'b00, w, IW'($urandom), $urandom, rw);
      else if (sel < 12)  step(1'b1, 1'b1, 1'b0, 2'b11, w, '0, '0, rw);
      else                step(1'b1, 1'b1, 1'b0, 2'($urandom_range(2)), w, IW'($urandom), $urandom, rw);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NW; i++) m_cnt[i] = 0;
    test_reset();
    test_push_read();
    test_overflow();
    test_bypass();
    test_underflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    settle();
    settle();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
